// File: rtl/RISCV_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
// Used by multicycle_ctrl and instr_class_decode.
package RISCV_pkg;

  typedef enum logic [2:0] {
    RST_S,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    HALT,
    TRAP
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_ILLEGAL
  } instr_class_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: maps a 7-bit RV32I opcode onto the
// instruction classes the sequencer distinguishes.
module instr_class_decode
  import RISCV_pkg::*;
(
  input  logic [6:0]   opcode,
  output instr_class_t cls
);

  always_comb begin
    unique case (opcode)
      OPC_R:      cls = CLS_R;
      OPC_I_ALU:  cls = CLS_I_ALU;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      default:    cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer with imem/dmem ready-ack handshakes.
// Optional `ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of retiring as NOPs.
module multicycle_ctrl
  import RISCV_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instruction,
  input  logic                ALU_zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                halt_req,
  output logic                imem_req,
  output logic                ir_wr,
  output logic                pc_wr,
  output logic [1:0]          pc_src,
  output logic [1:0]          alu_op,
  output logic                alu_src,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                mem_reg,
  output logic                reg_wr,
  output logic                halted,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  ctrl_state_t  state, state_nx;
  instr_class_t cls;
  logic [6:0]   opcode_q;
  logic [2:0]   funct3_q;
  // Set once a fetch request is outstanding, so a late halt_req cannot withdraw it.
  logic         fetch_busy;

  logic unused_instr;
  assign unused_instr = ^{instruction[31:15], instruction[11:7]};

  instr_class_decode u_decode (
    .opcode (opcode_q),
    .cls    (cls)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; all control registers are reset so outputs are
  // defined the instant rst asserts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_S;
      fetch_busy <= 1'b0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      retired    <= '0;
    end else begin
      state      <= state_nx;
      fetch_busy <= (state == FETCH) && imem_req && !imem_ack;
      if (ir_wr) begin
        opcode_q <= instruction[6:0];
        funct3_q <= instruction[14:12];
      end
      if (pc_wr) retired <= retired + RETIRE_W'(1);
    end
  end

  // NOTE: every output and the next state get a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    pc_src   = PC_PLUS4;
    alu_op   = ALU_ADD;
    alu_src  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_reg  = 1'b0;
    reg_wr   = 1'b0;
    halted   = 1'b0;

    unique case (state)
      RST_S: state_nx = FETCH;

      FETCH: begin
        if (!fetch_busy && halt_req) begin
          state_nx = HALT;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_wr    = 1'b1;
            state_nx = DECODE;
          end
        end
      end

      DECODE: begin
        if (cls == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
          state_nx = TRAP;
`else
          state_nx = WB;
`endif
        end else begin
          state_nx = EXECUTE;
        end
      end

      EXECUTE: begin
        unique case (cls)
          CLS_R: begin
            alu_op   = ALU_FUNCT;
            state_nx = WB;
          end
          CLS_I_ALU: begin
            alu_op   = ALU_FUNCT;
            alu_src  = 1'b1;
            state_nx = WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src  = 1'b1;
            state_nx = MEM;
          end
          CLS_BRANCH: begin
            alu_op = ALU_SUB;
            pc_wr  = 1'b1;
            if ((funct3_q == F3_BEQ && ALU_zero) || (funct3_q == F3_BNE && !ALU_zero))
              pc_src = PC_BRANCH;
            state_nx = FETCH;
          end
          CLS_JAL: begin
            reg_wr   = 1'b1;
            pc_wr    = 1'b1;
            pc_src   = PC_JAL;
            state_nx = FETCH;
          end
          default: state_nx = FETCH;
        endcase
      end

      MEM: begin
        alu_src = 1'b1;
        if (cls == CLS_LOAD) mem_rd = 1'b1;
        else                 mem_wr = 1'b1;
        if (dmem_ack) begin
          if (cls == CLS_LOAD) begin
            state_nx = WB;
          end else begin
            pc_wr    = 1'b1;
            state_nx = FETCH;
          end
        end
      end

      WB: begin
        reg_wr   = (cls != CLS_ILLEGAL);
        mem_reg  = (cls == CLS_LOAD);
        pc_wr    = 1'b1;
        state_nx = FETCH;
      end

      HALT: begin
        halted = 1'b1;
        if (!halt_req) state_nx = FETCH;
      end

      TRAP: state_nx = TRAP;

      default: state_nx = RST_S;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign trap = (state == TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level timing model expands each
// directed instruction into its expected per-cycle output trace, compared every cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        ALU_zero, imem_ack, dmem_ack, halt_req;
  logic        imem_req, ir_wr, pc_wr, alu_src, mem_rd, mem_wr, mem_reg, reg_wr, halted, trap;
  logic [1:0]  pc_src, alu_op;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .ALU_zero(ALU_zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .halt_req(halt_req),
    .imem_req(imem_req), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src(alu_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_reg(mem_reg), .reg_wr(reg_wr), .halted(halted), .trap(trap),
    .retired(retired)
  );

  // One expected cycle: inputs to drive and outputs the DUT must show.
  typedef struct {
    logic [31:0] instr;
    logic        iack, dack, zero, halt;
    logic        imem_req, ir_wr, pc_wr;
    logic [1:0]  pc_src, alu_op;
    logic        alu_src, mem_rd, mem_wr, mem_reg, reg_wr, halted, trap;
    logic [31:0] retired;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] model_retired = '0;
  int          budget = -1;
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic cyc_t blank(input logic z);
    cyc_t c;
    c = '{default: '0};
    c.instr = 32'hFFFF_FFFF;
    c.zero  = z;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    if (budget == 0) return;
    if (budget > 0) budget--;
    c.retired = model_retired;
    if (c.pc_wr) model_retired++;
    q.push_back(c);
  endtask

  // Expand one instruction into its cycle trace from the ISA-level timing rules.
  task automatic push_instr(input logic [31:0] ins, input logic z, input int iw, input int dw,
                            input logic halt_mem, input logic stray);
    cyc_t c;
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    for (int i = 0; i < iw; i++) begin
      c = blank(z); c.imem_req = 1'b1; push(c);
    end
    c = blank(z); c.instr = ins; c.iack = 1'b1; c.imem_req = 1'b1; c.ir_wr = 1'b1; push(c);
    c = blank(z); c.iack = stray; c.dack = stray; push(c);
    case (opc)
      7'h33, 7'h13: begin
        c = blank(z); c.alu_op = 2'd2; c.alu_src = (opc == 7'h13); push(c);
        c = blank(z); c.reg_wr = 1'b1; c.pc_wr = 1'b1; push(c);
      end
      7'h03, 7'h23: begin
        c = blank(z); c.alu_src = 1'b1; push(c);
        for (int i = 0; i <= dw; i++) begin
          c = blank(z); c.alu_src = 1'b1; c.halt = halt_mem;
          if (opc == 7'h03) c.mem_rd = 1'b1; else c.mem_wr = 1'b1;
          if (i == dw) begin
            c.dack = 1'b1;
            if (opc == 7'h23) c.pc_wr = 1'b1;
          end
          push(c);
        end
        if (opc == 7'h03) begin
          c = blank(z); c.halt = halt_mem; c.reg_wr = 1'b1; c.mem_reg = 1'b1; c.pc_wr = 1'b1;
          push(c);
        end
      end
      7'h63: begin
        c = blank(z); c.alu_op = 2'd1; c.pc_wr = 1'b1;
        c.pc_src = ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z)) ? 2'd1 : 2'd0;
        push(c);
      end
      7'h6F: begin
        c = blank(z); c.reg_wr = 1'b1; c.pc_wr = 1'b1; c.pc_src = 2'd2; push(c);
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 11; i++) begin
          c = blank(z); c.iack = 1'b1; c.trap = 1'b1; push(c);
        end
`else
        c = blank(z); c.pc_wr = 1'b1; push(c);
`endif
      end
    endcase
  endtask

  // FETCH entered with halt_req high, n HALT cycles, then the release cycle.
  task automatic push_halt(input int n);
    cyc_t c;
    c = blank(1'b0); c.halt = 1'b1; push(c);
    for (int i = 0; i < n; i++) begin
      c = blank(1'b0); c.halt = 1'b1; c.halted = 1'b1; push(c);
    end
    c = blank(1'b0); c.halted = 1'b1; push(c);
  endtask

  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      instruction = c.instr; imem_ack = c.iack; dmem_ack = c.dack;
      ALU_zero = c.zero; halt_req = c.halt;
      #2;
      cyc++;
      check($sformatf("c%0d imem_req", cyc), 32'(imem_req), 32'(c.imem_req));
      check($sformatf("c%0d ir_wr", cyc),    32'(ir_wr),    32'(c.ir_wr));
      check($sformatf("c%0d pc_wr", cyc),    32'(pc_wr),    32'(c.pc_wr));
      check($sformatf("c%0d pc_src", cyc),   32'(pc_src),   32'(c.pc_src));
      check($sformatf("c%0d alu_op", cyc),   32'(alu_op),   32'(c.alu_op));
      check($sformatf("c%0d alu_src", cyc),  32'(alu_src),  32'(c.alu_src));
      check($sformatf("c%0d mem_rd", cyc),   32'(mem_rd),   32'(c.mem_rd));
      check($sformatf("c%0d mem_wr", cyc),   32'(mem_wr),   32'(c.mem_wr));
      check($sformatf("c%0d mem_reg", cyc),  32'(mem_reg),  32'(c.mem_reg));
      check($sformatf("c%0d reg_wr", cyc),   32'(reg_wr),   32'(c.reg_wr));
      check($sformatf("c%0d halted", cyc),   32'(halted),   32'(c.halted));
      check($sformatf("c%0d trap", cyc),     32'(trap),     32'(c.trap));
      check($sformatf("c%0d retired", cyc),  retired,       c.retired);
    end
  endtask

  // Idle cycle in FETCH (request pending, no ack) with a hand-computed retire count.
  task automatic gap(input string name, input logic [31:0] exp_ret);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0; instruction = 32'hFFFF_FFFF;
    #2;
    check(name, retired, exp_ret);
    check({name, "_fetch_req"}, 32'(imem_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instruction = '0; ALU_zero = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; halt_req = 1'b0;
    @(negedge clk); #1;
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_retired", retired, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_pc_wr", 32'(pc_wr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_s_no_fetch", 32'(imem_req), 32'd0);

    push_instr(32'h002081B3, 1'b0, 0, 0, 1'b0, 1'b0);
    run_queue();
    gap("after_add", 32'd1);

    push_instr(32'h0000A183, 1'b0, 0, 3, 1'b0, 1'b0);
    run_queue();
    gap("after_lw", 32'd2);

    push_instr(32'h00208463, 1'b1, 1, 0, 1'b0, 1'b0);
    push_instr(32'h00208463, 1'b0, 0, 0, 1'b0, 1'b1);
    push_instr(32'h00209463, 1'b0, 2, 0, 1'b0, 1'b0);
    push_instr(32'h00209463, 1'b1, 0, 0, 1'b0, 1'b0);
    push_instr(32'h0020C463, 1'b1, 0, 0, 1'b0, 1'b0);
    run_queue();
    gap("after_branches", 32'd7);

    push_instr(32'h00508093, 1'b0, 1, 0, 1'b0, 1'b0);
    push_instr(32'h008000EF, 1'b1, 0, 0, 1'b0, 1'b1);
    push_instr(32'h0020A223, 1'b0, 0, 2, 1'b0, 1'b1);
    run_queue();
    gap("after_addi_jal_sw", 32'd10);

    push_instr(32'h0000A183, 1'b0, 0, 1, 1'b1, 1'b0);
    push_halt(3);
    push_instr(32'h002081B3, 1'b0, 0, 0, 1'b0, 1'b0);
    run_queue();
    gap("after_halt", 32'd12);

`ifndef ILLEGAL_TRAP_EN
    push_instr(32'h0000007F, 1'b0, 0, 0, 1'b0, 1'b0);
    push_instr(32'h002081B3, 1'b0, 0, 0, 1'b0, 1'b0);
    run_queue();
    gap("after_illegal_nop", 32'd14);
`endif

    budget = 5;
    push_instr(32'h0020A223, 1'b0, 0, 20, 1'b0, 1'b0);
    budget = -1;
    run_queue();
    @(negedge clk); #1;
    check("store_wait_mem_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_alu_src", 32'(alu_src), 32'd0);
    check("rst_mid_pc_wr", 32'(pc_wr), 32'd0);
    check("rst_mid_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_retired = '0;
    #2;
    check("rst_s_after_pulse", 32'(imem_req), 32'd0);
    push_instr(32'h002081B3, 1'b0, 0, 0, 1'b0, 1'b0);
    run_queue();
    gap("after_reset_add", 32'd1);

`ifdef ILLEGAL_TRAP_EN
    push_instr(32'h0000007F, 1'b0, 0, 0, 1'b0, 1'b0);
    run_queue();
    check("trap_sticky", 32'(trap), 32'd1);
    check("trap_retired", retired, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
